// File: rtl/cordic_phase_feeder.sv
// Purpose: feeds a downstream CORDIC with quadrant-folded phase words and un-folds its results.
// Latency: start vector one cycle after enable; cos/sin one cycle after cordic_valid_i.
// Backpressure: one transaction in flight; a missing result is abandoned after TIMEOUT_CYCLES WAIT cycles.
module cordic_phase_feeder #(
    parameter int N_FRAC         = 7,
    parameter int X_INIT         = 78,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     enable_i,
    input  logic [7:0]               freq_word_i,
    input  logic                     phase_load_i,
    input  logic [7:0]               phase_i,
    output logic signed [N_FRAC:0]   x_o,
    output logic signed [N_FRAC:0]   y_o,
    output logic signed [N_FRAC:0]   z_o,
    output logic                     data_out_valid_strobe_o,
    input  logic signed [N_FRAC:0]   cordic_x_i,
    input  logic signed [N_FRAC:0]   cordic_y_i,
    input  logic                     cordic_valid_i,
    output logic signed [N_FRAC:0]   cos_o,
    output logic signed [N_FRAC:0]   sin_o,
    output logic                     sample_valid_o,
    output logic                     busy_o,
    output logic                     timeout_o
);

    localparam int DW = N_FRAC + 1;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic signed [DW-1:0] D_MIN = {1'b1, {N_FRAC{1'b0}}};
    localparam logic signed [DW-1:0] D_MAX = {1'b0, {N_FRAC{1'b1}}};
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t              r_state;
    logic [7:0]          r_phase;
    logic                r_fold;
    logic [CW-1:0]       r_cnt;
    logic signed [DW-1:0] r_x, r_y, r_z, r_cos, r_sin;
    logic                r_strobe, r_sample_vld, r_busy, r_timeout;

    logic signed [7:0]    w_s;
    logic                 w_fold;
    logic signed [7:0]    w_z_fold;
    logic signed [DW-1:0] w_neg_x, w_neg_y;

    // Fold the accumulator into [-64, 63]; adding 128 mod 256 is a flip of the sign bit.
    always_comb begin
        w_s      = signed'(r_phase);
        w_fold   = (w_s < -8'sd64) || (w_s > 8'sd63);
        w_z_fold = w_fold ? signed'(r_phase ^ 8'h80) : w_s;
        w_neg_x  = (cordic_x_i == D_MIN) ? D_MAX : -cordic_x_i;
        w_neg_y  = (cordic_y_i == D_MIN) ? D_MAX : -cordic_y_i;
    end

    // Transaction FSM with registered outputs and the phase accumulator.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state      <= S_IDLE;
            r_phase      <= '0;
            r_fold       <= 1'b0;
            r_cnt        <= '0;
            r_x          <= '0;
            r_y          <= '0;
            r_z          <= '0;
            r_cos        <= '0;
            r_sin        <= '0;
            r_strobe     <= 1'b0;
            r_sample_vld <= 1'b0;
            r_busy       <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_strobe     <= 1'b0;
            r_sample_vld <= 1'b0;
            r_timeout    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (enable_i) begin
                        r_state  <= S_ISSUE;
                        r_x      <= DW'(X_INIT);
                        r_y      <= '0;
                        r_z      <= DW'(w_z_fold);
                        r_fold   <= w_fold;
                        r_strobe <= 1'b1;
                        r_busy   <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    r_state <= S_WAIT;
                    r_cnt   <= '0;
                end
                S_WAIT: begin
                    if (cordic_valid_i) begin
                        // A result arriving on the last WAIT cycle still wins over the timeout.
                        r_cos        <= r_fold ? w_neg_x : cordic_x_i;
                        r_sin        <= r_fold ? w_neg_y : cordic_y_i;
                        r_sample_vld <= 1'b1;
                        r_phase      <= r_phase + freq_word_i;
                        r_state      <= S_IDLE;
                        r_busy       <= 1'b0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_timeout <= 1'b1;
                        r_state   <= S_IDLE;
                        r_busy    <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
            // A load overrides any advance in the same cycle; the in-flight fold/z are untouched.
            if (phase_load_i) begin
                r_phase <= phase_i;
            end
        end
    end

    assign x_o                     = r_x;
    assign y_o                     = r_y;
    assign z_o                     = r_z;
    assign cos_o                   = r_cos;
    assign sin_o                   = r_sin;
    assign data_out_valid_strobe_o = r_strobe;
    assign sample_valid_o          = r_sample_vld;
    assign busy_o                  = r_busy;
    assign timeout_o               = r_timeout;

endmodule

// File: tb/tb_cordic_phase_feeder.sv
module tb_cordic_phase_feeder;

    localparam int N  = 8;
    localparam int TO = 15;

    logic                clk_i = 1'b0;
    logic                rst_i;
    logic                enable_i;
    logic [7:0]          freq_word_i;
    logic                phase_load_i;
    logic [7:0]          phase_i;
    logic signed [N-1:0] x_o, y_o, z_o;
    logic                data_out_valid_strobe_o;
    logic signed [N-1:0] cordic_x_i, cordic_y_i;
    logic                cordic_valid_i;
    logic signed [N-1:0] cos_o, sin_o;
    logic                sample_valid_o, busy_o, timeout_o;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: phase accumulator and last delivered result.
    int m_phase = 0;
    int m_cos   = 0;
    int m_sin   = 0;

    cordic_phase_feeder #(.N_FRAC(7), .X_INIT(78), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i                   (clk_i),
        .rst_i                   (rst_i),
        .enable_i                (enable_i),
        .freq_word_i             (freq_word_i),
        .phase_load_i            (phase_load_i),
        .phase_i                 (phase_i),
        .x_o                     (x_o),
        .y_o                     (y_o),
        .z_o                     (z_o),
        .data_out_valid_strobe_o (data_out_valid_strobe_o),
        .cordic_x_i              (cordic_x_i),
        .cordic_y_i              (cordic_y_i),
        .cordic_valid_i          (cordic_valid_i),
        .cos_o                   (cos_o),
        .sin_o                   (sin_o),
        .sample_valid_o          (sample_valid_o),
        .busy_o                  (busy_o),
        .timeout_o               (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0] phase;
        logic [7:0] cx;
        logic [7:0] cy;
        int         exp_z;
        int         exp_cos;
        int         exp_sin;
    } vec_t;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic int negsat(input int v);
        int r;
        r = -v;
        if (r > 127) r = 127;
        return r;
    endfunction

    task automatic do_load(input logic [7:0] v);
        phase_load_i = 1'b1;
        phase_i      = v;
        tick();
        phase_load_i = 1'b0;
        m_phase      = int'(v);
    endtask

    // One transaction from IDLE: result returned on WAIT cycle dly (dly > TO means none).
    task automatic run_txn(input logic [7:0] fw, input int dly, input logic [7:0] cx,
                           input logic [7:0] cy, input bit ld_done, input logic [7:0] ld_done_val,
                           input bit ld_wait, input logic [7:0] ld_wait_val);
        int  ez;
        bit  ef;
        bit  done;
        bit  ld_now;
        int  ld_val;
        ez = ((m_phase + 64) % 128) - 64;
        ef = ((m_phase + 64) % 256) >= 128;
        freq_word_i = fw;
        enable_i    = 1'b1;
        tick();
        enable_i = 1'b0;
        chk("issue_strobe", int'(data_out_valid_strobe_o), 1);
        chk("issue_busy", int'(busy_o), 1);
        chk("issue_x", int'(x_o), 78);
        chk("issue_y", int'(y_o), 0);
        chk("issue_z", int'(z_o), ez);
        tick();
        chk("strobe_one_cycle", int'(data_out_valid_strobe_o), 0);
        chk("wait_busy", int'(busy_o), 1);
        done = 1'b0;
        for (int k = 1; k <= TO + 5 && !done; k++) begin
            ld_now = 1'b0;
            ld_val = 0;
            if (ld_wait && k == 1) begin
                ld_now = 1'b1; ld_val = int'(ld_wait_val);
            end
            if (ld_done && k == dly) begin
                ld_now = 1'b1; ld_val = int'(ld_done_val);
            end
            phase_load_i = ld_now;
            phase_i      = 8'(ld_val);
            if (k == dly) begin
                cordic_valid_i = 1'b1;
                cordic_x_i     = cx;
                cordic_y_i     = cy;
            end
            tick();
            phase_load_i   = 1'b0;
            cordic_valid_i = 1'b0;
            if (k == dly) begin
                m_cos   = ef ? negsat(int'($signed(cx))) : int'($signed(cx));
                m_sin   = ef ? negsat(int'($signed(cy))) : int'($signed(cy));
                m_phase = ld_now ? ld_val : (m_phase + int'(fw)) % 256;
                chk("sample_valid", int'(sample_valid_o), 1);
                chk("cos", int'(cos_o), m_cos);
                chk("sin", int'(sin_o), m_sin);
                chk("done_busy", int'(busy_o), 0);
                chk("no_timeout_on_valid", int'(timeout_o), 0);
                done = 1'b1;
            end else begin
                if (ld_now) m_phase = ld_val;
                if (k == TO) begin
                    chk("timeout_pulse", int'(timeout_o), 1);
                    chk("timeout_busy", int'(busy_o), 0);
                    chk("timeout_no_sample", int'(sample_valid_o), 0);
                    chk("timeout_cos_held", int'(cos_o), m_cos);
                    chk("timeout_sin_held", int'(sin_o), m_sin);
                    done = 1'b1;
                end else begin
                    chk("early_timeout", int'(timeout_o), 0);
                end
            end
        end
        if (!done) chk("txn_bound", 0, 1);
        tick();
        chk("sample_one_cycle", int'(sample_valid_o), 0);
        chk("timeout_one_cycle", int'(timeout_o), 0);
        chk("z_held", int'(z_o), ez);
        chk("idle_busy", int'(busy_o), 0);
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{8'd128, 8'd127, 8'h00,   0, -127,    0};
        vecs[1] = '{8'd64,  8'h00,  8'h80, -64,    0,  127};
        vecs[2] = '{8'd63,  8'd10,  8'd20,  63,   10,   20};
        vecs[3] = '{8'd192, 8'd5,   8'hF9, -64,    5,   -7};
        vecs[4] = '{8'd191, 8'h80,  8'h80,  63,  127,  127};
        vecs[5] = '{8'd32,  8'h80,  8'h7F,  32, -128,  127};
        vecs[6] = '{8'd200, 8'd100, 8'h9C, -56,  100, -100};
        vecs[7] = '{8'd100, 8'd1,   8'hFF, -28,   -1,    1};

        rst_i = 1'b0; enable_i = 1'b0; freq_word_i = '0; phase_load_i = 1'b0;
        phase_i = '0; cordic_x_i = '0; cordic_y_i = '0; cordic_valid_i = 1'b0;
        tick(); tick();
        chk("rst_x", int'(x_o), 0);
        chk("rst_z", int'(z_o), 0);
        chk("rst_cos", int'(cos_o), 0);
        chk("rst_strobe", int'(data_out_valid_strobe_o), 0);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_timeout", int'(timeout_o), 0);
        rst_i = 1'b1;
        tick();

        // Base sample straight out of reset at phase 0.
        run_txn(8'd0, 1, 8'd127, 8'd0, 1'b0, 8'd0, 1'b0, 8'd0);

        // Directed fold / saturation table.
        for (int i = 0; i < 8; i++) begin
            do_load(vecs[i].phase);
            chk("tbl_model_z", ((m_phase + 64) % 128) - 64, vecs[i].exp_z);
            run_txn(8'd0, 1 + (i % 3), vecs[i].cx, vecs[i].cy, 1'b0, 8'd0, 1'b0, 8'd0);
            chk("tbl_cos", int'(cos_o), vecs[i].exp_cos);
            chk("tbl_sin", int'(sin_o), vecs[i].exp_sin);
        end

        // Wrap, then load priority on the completion cycle.
        do_load(8'hC0);
        run_txn(8'h40, 1, 8'd3, 8'd4, 1'b0, 8'd0, 1'b0, 8'd0);
        run_txn(8'h40, 2, 8'd3, 8'd4, 1'b1, 8'h10, 1'b0, 8'd0);
        run_txn(8'd0, 1, 8'd3, 8'd4, 1'b0, 8'd0, 1'b0, 8'd0);

        // Timeout, then a result exactly on the last WAIT cycle.
        do_load(8'h25);
        run_txn(8'h11, TO + 1, 8'd9, 8'd9, 1'b0, 8'd0, 1'b0, 8'd0);
        run_txn(8'h11, TO, 8'd9, 8'd9, 1'b0, 8'd0, 1'b0, 8'd0);

        // Load during WAIT must not disturb the in-flight fold.
        do_load(8'd130);
        run_txn(8'h05, 4, 8'd50, 8'd60, 1'b0, 8'd0, 1'b1, 8'd10);
        run_txn(8'h00, 1, 8'd50, 8'd60, 1'b0, 8'd0, 1'b0, 8'd0);

        // Randomized transactions against the model.
        for (int i = 0; i < 40; i++) begin
            run_txn(8'($urandom), int'($urandom_range(1, TO + 3)), 8'($urandom), 8'($urandom),
                    ($urandom_range(0, 4) == 0), 8'($urandom),
                    ($urandom_range(0, 4) == 0), 8'($urandom));
            if ($urandom_range(0, 5) == 0) do_load(8'($urandom));
        end

        // Reset in the middle of WAIT discards the transaction.
        do_load(8'h20);
        enable_i = 1'b1;
        tick();
        enable_i = 1'b0;
        chk("pre_rst_z", int'(z_o), 32);
        tick(); tick();
        rst_i = 1'b0;
        #1;
        chk("async_rst_busy", int'(busy_o), 0);
        chk("async_rst_z", int'(z_o), 0);
        chk("async_rst_x", int'(x_o), 0);
        chk("async_rst_cos", int'(cos_o), 0);
        tick();
        rst_i = 1'b1;
        m_phase = 0; m_cos = 0; m_sin = 0;
        cordic_valid_i = 1'b1; cordic_x_i = 8'sd50; cordic_y_i = 8'sd40;
        tick();
        cordic_valid_i = 1'b0;
        chk("post_rst_no_sample", int'(sample_valid_o), 0);
        chk("post_rst_cos", int'(cos_o), 0);
        chk("post_rst_sin", int'(sin_o), 0);
        chk("post_rst_busy", int'(busy_o), 0);
        chk("post_rst_strobe", int'(data_out_valid_strobe_o), 0);
        chk("post_rst_y", int'(y_o), 0);
        tick();
        chk("post_rst_no_sample2", int'(sample_valid_o), 0);
        run_txn(8'd0, 1, 8'd20, 8'd30, 1'b0, 8'd0, 1'b0, 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cordic_phase_feeder.md
CORDIC_PHASE_FEEDER -- requirements
Module: cordic_phase_feeder

Interface
REQ-001 Parameter: N_FRAC, 7, data words are N_FRAC+1 bits, signed two's complement.
REQ-002 Parameter: X_INIT, 78, starting x word issued to the CORDIC (CORDIC gain compensation, ~0.607 in Q0.7).
REQ-003 Parameter: TIMEOUT_CYCLES, 15, maximum number of WAIT cycles before the transaction is abandoned.
REQ-004 Reset is asynchronous, active-low.
REQ-005 Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous reset, active-low.
- enable_i  in  1  permits a new transaction to start from IDLE.
- freq_word_i  in  8  phase increment per completed sample.
- phase_load_i  in  1  loads phase_i into the phase accumulator.
- phase_i  in  8  load value; 256 units = 2*pi.
- x_o, y_o, z_o  out  N_FRAC+1 each  start vector and angle driven to the downstream CORDIC.
- data_out_valid_strobe_o  out  1  one-cycle start strobe to the CORDIC.
- cordic_x_i, cordic_y_i  in  N_FRAC+1 each  CORDIC results.
- cordic_valid_i  in  1  CORDIC result-valid strobe.
- cos_o, sin_o  out  N_FRAC+1 each  quadrant-corrected results.
- sample_valid_o  out  1  one-cycle result strobe.
- busy_o  out  1  high in ISSUE and WAIT.
- timeout_o  out  1  one-cycle pulse on an abandoned transaction.

Function
REQ-006 The FSM SHALL have states IDLE, ISSUE, and WAIT.
REQ-007 IDLE SHALL go to ISSUE when enable_i=1; otherwise it SHALL hold.
REQ-008 ISSUE SHALL last exactly one cycle, assert data_out_valid_strobe_o, and go to WAIT.
REQ-009 x_o, y_o, and z_o SHALL be registered on the IDLE->ISSUE transition and held stable until the next ISSUE.
REQ-010 Quadrant fold uses s = phase accumulator interpreted as signed 8-bit. If -64 <= s <= 63: z_o = s and fold flag = 0. Otherwise: z_o = s+128 (mod 256) and fold flag = 1.
REQ-011 The fold flag SHALL be registered at ISSUE and held until the result is delivered.
REQ-012 Start vector SHALL be x_o = X_INIT and y_o = 0.
REQ-013 In WAIT, when cordic_valid_i=1:
- capture cordic_x_i and cordic_y_i;
- if fold=1, negate both, saturating -128 to +127;
- drive cos_o and sin_o from the next cycle and hold them until the next capture;
- pulse sample_valid_o for one cycle, aligned with the new cos_o/sin_o;
- advance phase accumulator by freq_word_i (mod 256);
- return to IDLE.
REQ-014 Latency SHALL be one cycle from cordic_valid_i to sample_valid_o.
REQ-015 cordic_valid_i SHALL be ignored outside WAIT.
REQ-016 A WAIT cycle counter SHALL reset on entry to WAIT.
REQ-017 On the TIMEOUT_CYCLES-th WAIT cycle without cordic_valid_i:
- pulse timeout_o;
- return to IDLE;
- leave the phase accumulator unadvanced;
- leave cos_o and sin_o unchanged.
REQ-018 If cordic_valid_i arrives on the same cycle as the timeout, the valid result SHALL win and timeout_o SHALL stay 0.
REQ-019 phase_load_i SHALL be accepted in any state and SHALL take priority over the advance in the same cycle.
REQ-020 A phase load during WAIT SHALL NOT alter the fold flag or z_o of the in-flight transaction.
REQ-021 enable_i deasserted during ISSUE or WAIT SHALL NOT abort the transaction.

Reset
REQ-022 While rst_i=0, the block SHALL immediately force:
- state IDLE;
- phase accumulator 0, fold flag 0, WAIT counter 0;
- x_o, y_o, z_o, cos_o, sin_o all 0;
- data_out_valid_strobe_o, sample_valid_o, busy_o, timeout_o all 0.
REQ-023 A reset asserted mid-transaction SHALL discard that transaction, and no sample_valid_o SHALL follow the reset.

Verification
REQ-024 The bench SHALL cover the following scenarios:
- Base sample: reset release, enable_i=1, phase 0 -> next cycle x_o=78, y_o=0, z_o=0, strobe high for 1 cycle; return cordic 127/0 -> next cycle cos_o=127, sin_o=0, sample_valid_o=1.
- Fold: load phase_i=128, enable -> z_o=0, fold=1; return 127/0 -> cos_o=-127, sin_o=0.
- Fold boundary and saturation: load phase_i=64 -> z_o=-64, fold=1; return 0/-128 -> cos_o=0, sin_o=127.
- Wrap and load priority: freq_word_i=0x40, phase 0xC0, one sample -> phase 0x00; phase_load_i with phase_i=0x10 on the completion cycle -> phase 0x10.
- Timeout: no cordic_valid_i for 15 WAIT cycles -> timeout_o pulses once, busy_o=0, phase unchanged; valid on the 15th cycle -> sample_valid_o instead, no timeout_o.
- Reset in WAIT: rst_i=0 for 1 cycle during WAIT, then cordic_valid_i=1 -> no sample_valid_o, all outputs 0, state IDLE.
